// File: rtl/sga_pkg.sv
// rtl/sga_pkg.sv - shared constants and state encoding for the snake-body sequencer
package sga_pkg;

  localparam int         SGA_ADDR_W    = 4;
  localparam int         SGA_COORD_W   = 8;
  localparam int         SGA_MAX_LEN   = 15;
  localparam logic [7:0] SGA_INIT_HEAD = 8'h44;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_HEAD  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/sga_body_sequencer_if.sv
// rtl/sga_body_sequencer_if.sv - control and body-RAM signals of the body sequencer
interface sga_body_sequencer_if
  import sga_pkg::*;
#(
  parameter int ADDR_W  = SGA_ADDR_W,
  parameter int COORD_W = SGA_COORD_W
);

  logic               clear;
  logic               start;
  logic               grow;
  logic [COORD_W-1:0] new_head;
  logic [COORD_W-1:0] ram_rdata;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COORD_W-1:0] ram_wdata;
  logic               ram_we;
  logic               busy;
  logic               done;
  logic               hit_body;
  logic [ADDR_W-1:0]  size;
  logic               full;

  // master: game control unit plus body RAM; slave: the sequencer
  modport master (
    output clear, start, grow, new_head, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, busy, done, hit_body, size, full
  );

  modport slave (
    input  clear, start, grow, new_head, ram_rdata,
    output ram_addr, ram_wdata, ram_we, busy, done, hit_body, size, full
  );

endinterface

// File: rtl/sga_seg_counter.sv
// rtl/sga_seg_counter.sv - segment index down-counter with load and next-zero flag
module sga_seg_counter
  import sga_pkg::*;
#(
  parameter int ADDR_W = SGA_ADDR_W
) (
  input  logic              clock,
  input  logic              restart_n,
  input  logic              load,
  input  logic              dec,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] idx,
  output logic              next_zero
);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = load_val;
    end else if (dec) begin
      idx_d = idx_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Flag reflects the value the counter takes at the coming edge
  assign idx       = idx_q;
  assign next_zero = (idx_d == '0);

endmodule

// File: rtl/sga_body_sequencer.sv
// rtl/sga_body_sequencer.sv - shifts the snake body one slot per move, writes the new head, flags self-collision
module sga_body_sequencer
  import sga_pkg::*;
#(
  parameter int                 ADDR_W    = SGA_ADDR_W,
  parameter int                 COORD_W   = SGA_COORD_W,
  parameter int                 MAX_LEN   = SGA_MAX_LEN,
  parameter logic [COORD_W-1:0] INIT_HEAD = SGA_INIT_HEAD
) (
  input logic                 clock,
  input logic                 restart_n,
  sga_body_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  size_q, size_d;
  logic               grow_q, grow_d;
  logic [COORD_W-1:0] head_q, head_d;
  logic [COORD_W-1:0] seg_q, seg_d;
  logic               hit_q, hit_d;

  logic               full;
  logic               cnt_load;
  logic               cnt_dec;
  logic               idx_next_zero;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  load_val;

  assign full     = (size_q == ADDR_W'(MAX_LEN));
  assign load_val = size_q - ADDR_W'(1) + ADDR_W'(bus.grow & ~full);
  assign cnt_load = (state_q == S_IDLE) && bus.start && !bus.clear;
  assign cnt_dec  = (state_q == S_WRITE);

  sga_seg_counter #(.ADDR_W(ADDR_W)) u_seg_counter (
    .clock     (clock),
    .restart_n (restart_n),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_val  (load_val),
    .idx       (idx),
    .next_zero (idx_next_zero)
  );

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    grow_d        = grow_q;
    head_d        = head_q;
    seg_d         = seg_q;
    hit_d         = hit_q;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          hit_d   = 1'b0;
          state_d = S_INIT;
        end else if (bus.start) begin
          grow_d  = bus.grow & ~full;
          head_d  = bus.new_head;
          hit_d   = 1'b0;
          state_d = idx_next_zero ? S_HEAD : S_READ;
        end
      end
      S_INIT: begin
        bus.ram_wdata = INIT_HEAD;
        bus.ram_we    = 1'b1;
        size_d        = ADDR_W'(1);
        hit_d         = 1'b0;
        state_d       = S_DONE;
      end
      S_READ: begin
        bus.ram_addr = idx - ADDR_W'(1);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // Read data for idx-1 lands this cycle; compare it before it is shifted
        bus.ram_addr = idx - ADDR_W'(1);
        seg_d        = bus.ram_rdata;
        if (bus.ram_rdata == head_q) begin
          hit_d = 1'b1;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.ram_addr  = idx;
        bus.ram_wdata = seg_q;
        bus.ram_we    = 1'b1;
        state_d       = idx_next_zero ? S_HEAD : S_READ;
      end
      S_HEAD: begin
        bus.ram_wdata = head_q;
        bus.ram_we    = 1'b1;
        size_d        = size_q + ADDR_W'(grow_q);
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= S_IDLE;
      size_q  <= ADDR_W'(1);
      grow_q  <= 1'b0;
      head_q  <= '0;
      seg_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      grow_q  <= grow_d;
      head_q  <= head_d;
      seg_q   <= seg_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.hit_body = hit_q;
  assign bus.size     = size_q;
  assign bus.full     = full;

endmodule

// File: tb/tb_sga_body_sequencer.sv
// tb/tb_sga_body_sequencer.sv - directed vector bench for sga_body_sequencer with a behavioural body RAM
module tb_sga_body_sequencer;
  import sga_pkg::*;

  typedef struct {
    logic            reload;
    logic [3:0][7:0] pre;
    logic            grow;
    logic [7:0]      head;
    int              lat;
    int              size;
    logic            hit;
  } vec_t;

  logic clock = 1'b0;
  logic restart_n;
  always #5 clock = ~clock;

  sga_body_sequencer_if bus_if ();

  sga_body_sequencer dut (
    .clock     (clock),
    .restart_n (restart_n),
    .bus       (bus_if)
  );

  logic [7:0]      mem [0:15];
  logic            pre_en;
  logic [3:0][7:0] pre_body;

  always @(posedge clock) begin
    if (pre_en) begin
      for (int i = 0; i < 4; i++) mem[i] <= pre_body[i];
    end else if (bus_if.ram_we) begin
      mem[bus_if.ram_addr] <= bus_if.ram_wdata;
    end
    bus_if.ram_rdata <= mem[bus_if.ram_addr];
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_body [0:15];
  int         ref_size;
  vec_t       vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 100 && bus_if.done !== 1'b1) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic check_body(input string tag);
    bit ok = 1'b1;
    for (int i = 0; i < ref_size; i++) if (mem[i] !== ref_body[i]) ok = 1'b0;
    check({tag, " body contents"}, 32'(ok), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(posedge clock); #1;
    check({tag, " idle outputs"},
          32'({bus_if.done, bus_if.busy, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata}), 32'd0);
  endtask

  task automatic do_clear(input logic also_start, input string tag);
    int n;
    @(negedge clock);
    bus_if.clear = 1'b1; bus_if.start = also_start; bus_if.grow = 1'b1; bus_if.new_head = 8'h99;
    @(posedge clock); #1;
    bus_if.clear = 1'b0; bus_if.start = 1'b0; bus_if.grow = 1'b0;
    check({tag, " busy"}, 32'(bus_if.busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'd1);
    check({tag, " size"}, 32'(bus_if.size), 32'd1);
    check({tag, " hit_body"}, 32'(bus_if.hit_body), 32'd0);
    check({tag, " mem0"}, 32'(mem[0]), 32'h44);
    ref_size    = 1;
    ref_body[0] = 8'h44;
    check_idle(tag);
  endtask

  task automatic do_move(input logic g, input logic [7:0] h, input int exp_lat,
                         input int exp_size, input logic exp_hit, input string tag);
    int n;
    int new_size;
    @(negedge clock);
    bus_if.start = 1'b1; bus_if.grow = g; bus_if.new_head = h;
    @(posedge clock); #1;
    bus_if.start = 1'b0; bus_if.grow = 1'b0;
    check({tag, " busy"}, 32'(bus_if.busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " size"}, 32'(bus_if.size), 32'(exp_size));
    check({tag, " hit_body"}, 32'(bus_if.hit_body), 32'(exp_hit));
    new_size = (g && ref_size < 15) ? ref_size + 1 : ref_size;
    for (int i = new_size - 1; i > 0; i--) ref_body[i] = ref_body[i-1];
    ref_body[0] = h;
    ref_size    = new_size;
    check_body(tag);
    check_idle(tag);
  endtask

  initial begin
    int n;
    int dones;

    vecs[0]  = '{1'b0, '0, 1'b0, 8'h45, 1,  1, 1'b0};
    vecs[1]  = '{1'b0, '0, 1'b0, 8'h43, 1,  1, 1'b0};
    vecs[2]  = '{1'b0, '0, 1'b1, 8'h44, 4,  2, 1'b0};
    vecs[3]  = '{1'b0, '0, 1'b1, 8'h45, 7,  3, 1'b0};
    vecs[4]  = '{1'b0, '0, 1'b1, 8'h46, 10, 4, 1'b0};
    vecs[5]  = '{1'b0, '0, 1'b0, 8'h32, 10, 4, 1'b0};
    vecs[6]  = '{1'b0, '0, 1'b0, 8'h33, 10, 4, 1'b0};
    vecs[7]  = '{1'b0, '0, 1'b0, 8'h23, 10, 4, 1'b0};
    vecs[8]  = '{1'b0, '0, 1'b0, 8'h22, 10, 4, 1'b0};
    vecs[9]  = '{1'b0, '0, 1'b0, 8'h32, 10, 4, 1'b0};
    vecs[10] = '{1'b1, {8'h32, 8'h33, 8'h23, 8'h22}, 1'b1, 8'h32, 13, 5, 1'b1};
    vecs[11] = '{1'b0, '0, 1'b1, 8'h11, 16, 6, 1'b0};

    restart_n = 1'b0;
    bus_if.clear = 1'b0; bus_if.start = 1'b0; bus_if.grow = 1'b0; bus_if.new_head = '0;
    pre_en = 1'b0; pre_body = '0;
    ref_size = 1;
    repeat (3) @(posedge clock);
    #1;
    check("reset outputs",
          32'({bus_if.busy, bus_if.done, bus_if.hit_body, bus_if.full, bus_if.ram_we,
               bus_if.ram_addr, bus_if.ram_wdata}), 32'd0);
    check("reset size", 32'(bus_if.size), 32'd1);
    @(negedge clock);
    restart_n = 1'b1;

    do_clear(1'b1, "clear_over_start");

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].reload) begin
        @(negedge clock);
        pre_en = 1'b1; pre_body = vecs[v].pre;
        @(negedge clock);
        pre_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_body[i] = vecs[v].pre[i];
      end
      do_move(vecs[v].grow, vecs[v].head, vecs[v].lat, vecs[v].size, vecs[v].hit,
              $sformatf("vec%0d", v));
      if (vecs[v].hit) begin
        repeat (3) @(posedge clock);
        #1;
        check($sformatf("vec%0d hit held", v), 32'(bus_if.hit_body), 32'd1);
      end
    end

    for (int i = 0; i < 9; i++) begin
      do_move(1'b1, 8'(8'h60 + i), 3 * (6 + i) + 1, 7 + i, 1'b0, $sformatf("grow%0d", i));
    end
    check("full at max", 32'(bus_if.full), 32'd1);
    do_move(1'b1, 8'h70, 43, 15, 1'b0, "grow_when_full");
    check("full after", 32'(bus_if.full), 32'd1);

    @(negedge clock);
    bus_if.start = 1'b1; bus_if.grow = 1'b0; bus_if.new_head = 8'h71;
    @(posedge clock); #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("in WRITE before reset", 32'(bus_if.ram_we), 32'd1);
    restart_n = 1'b0;
    #1;
    check("mid-op reset outputs",
          32'({bus_if.busy, bus_if.ram_we, bus_if.done, bus_if.full, bus_if.hit_body}), 32'd0);
    check("mid-op reset size", 32'(bus_if.size), 32'd1);
    @(negedge clock);
    restart_n = 1'b1;
    check_idle("after reset");

    do_clear(1'b0, "clear");

    @(negedge clock);
    bus_if.start = 1'b1; bus_if.grow = 1'b1; bus_if.new_head = 8'h45;
    @(posedge clock); #1;
    bus_if.start = 1'b0; bus_if.grow = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.grow = 1'b1; bus_if.new_head = 8'h99;
      end
      @(posedge clock); #1;
      bus_if.start = 1'b0; bus_if.grow = 1'b0;
      if (bus_if.done) dones++;
    end
    check("busy start ignored dones", 32'(dones), 32'd1);
    check("busy start ignored size", 32'(bus_if.size), 32'd2);
    check("busy start mem0", 32'(mem[0]), 32'h45);
    check("busy start mem1", 32'(mem[1]), 32'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
